ring_heater_lock_ctrl: RTL and testbench
========================================

Name: ring_heater_lock_ctrl

Overview:
Closed-loop thermal lock controller for a resonant ring. Consumes digitized through-port power samples taken at the ring's through port, finds the heater code that minimises that power (ring on resonance), then tracks it by hill-climbing. Drives the ring heater with a 1-bit PDM stream at the heater's tuning bit width; this is the digital stage that feeds the thermal tuner.

Parameters:
BIT_WIDTH, 8, heater code width (matches thermal tuner bit_width)
PWR_WIDTH, 10, power sample code width
SETTLE_CYCLES, 256, clk cycles to wait after any heater code change before a sample is accepted (>=1)
STEP, 1, hill-climb step in code LSBs (>=1)
LOSS_THRESH, 32, lock-loss margin above ref power (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
enable  in  1  run lock loop; 0 forces IDLE
pwr_valid  in  1  pwr_code valid this cycle
pwr_code  in  PWR_WIDTH  unsigned through-port power sample
heater_pdm  out  1  PDM heater drive to tuner
heater_code  out  BIT_WIDTH  current heater code
locked  out  1  loop in tracking
sweep_busy  out  1  initial sweep in progress

Behaviour:
- Reset (async): state=IDLE; heater_code=0, heater_pdm=0, locked=0, sweep_busy=0; accumulator=0; best_code=0; best_pwr=all ones; dir=+1; settle counter=0.
- Settle: any heater_code change reloads counter with SETTLE_CYCLES; while counter!=0, pwr_valid ignored. First pwr_valid with counter==0 is "accepted". Exactly one sample accepted per settle window.
- States: IDLE, SWEEP, TRACK_REF, TRACK_PROBE.
- IDLE: heater_code=0, locked=0. enable=1 -> SWEEP next cycle, heater_code=0, settle reload, best_pwr=all ones, best_code=0.
- SWEEP (sweep_busy=1): on accepted sample, if pwr_code < best_pwr (strict; ties keep lower code) update best_pwr/best_code. If heater_code != 2^BIT_WIDTH-1: heater_code+1, reload. Else -> TRACK_REF with heater_code = best_code including that cycle's update; locked=1 from that cycle; reload.
- TRACK_REF: accepted sample -> ref_pwr=sample; compute probe = heater_code + dir*STEP. If probe outside [0, 2^BIT_WIDTH-1] flip dir, stay TRACK_REF, no code change, no reload (next valid sample re-measures). Else heater_code=probe, save prev_code, reload, -> TRACK_PROBE.
- TRACK_PROBE: accepted sample: if sample < ref_pwr keep code; else heater_code=prev_code and flip dir. Reload, -> TRACK_REF.
- enable=0 in any state -> IDLE next cycle (heater_code 0, locked 0, sweep_busy 0); in-flight sample discarded. enable and pwr_valid in same cycle: enable=0 wins.
- PDM: first-order sigma-delta, BIT_WIDTH accumulator: {carry,acc} <= acc + heater_code each cycle; heater_pdm <= carry (one-cycle registered). Duty = heater_code/2^BIT_WIDTH exactly over 2^BIT_WIDTH cycles; code 0 -> constant 0. Accumulator not cleared on code changes.

Optional Feature:
Macro RING_LOCK_LOSS_DETECT_EN. With: in TRACK_REF, 4 consecutive accepted samples with pwr_code > ref_pwr + LOSS_THRESH (PWR_WIDTH+1-bit compare, no wrap) -> locked=0, -> SWEEP (fresh sweep as from IDLE); any non-exceeding sample clears the count. Without: no counter, tracking never self-aborts.

Decomposition:
Package ring_lock_pkg: state enum (IDLE, SWEEP, TRACK_REF, TRACK_PROBE), dir encoding, loss-count constant 4. Sub-module pdm_modulator (BIT_WIDTH param; clk, rst, code in, pdm out) for the sigma-delta.

Test Plan:
- Reset mid-TRACK_PROBE -> same cycle heater_code=0, heater_pdm=0, locked=0; state IDLE.
- PDM only, BIT_WIDTH=8, code=64 held 256 cycles -> exactly 64 ones; code=0 -> zero ones.
- BIT_WIDTH=4, SETTLE_CYCLES=4, power model = |code-9|*50 -> sweep visits 0..15, ends with heater_code=9, locked=1, sweep_busy=0.
- Tie: equal minimum at codes 5 and 6 -> best_code=5.
- Track: after lock at 9, shift model minimum to 11 -> code reaches 11 within 6 accepted samples, then oscillates 11<->10/12, never drifts further.
- pwr_valid pulsed during settle window -> ignored (no code change); with RING_LOCK_LOSS_DETECT_EN, power +100 for 4 samples -> locked drops, sweep_busy=1, heater_code=0.

Source files
------------

// File: rtl/ring_lock_pkg.sv
// Shared encodings for the ring heater lock controller: FSM states,
// hill-climb direction and the lock-loss run length.
package ring_lock_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SWEEP       = 2'd1,
        TRACK_REF   = 2'd2,
        TRACK_PROBE = 2'd3
    } lock_state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int unsigned LOSS_COUNT = 4;

endpackage

// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM: the carry of a BIT_WIDTH accumulator is the
// one-cycle registered heater drive, giving duty code/2^BIT_WIDTH exactly.
module pdm_modulator #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] code,
    output logic                 pdm
);

    logic [BIT_WIDTH-1:0] acc_q;
    logic                 pdm_q;
    logic [BIT_WIDTH:0]   sum;

    always_comb sum = {1'b0, acc_q} + {1'b0, code};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= sum[BIT_WIDTH-1:0];
            pdm_q <= sum[BIT_WIDTH];
        end
    end

    assign pdm = pdm_q;

endmodule

// File: rtl/ring_heater_lock_ctrl.sv
// Thermal lock for a resonant ring: sweeps the heater code for minimum through-port
// power, then hill-climbs around it. Optional lock-loss abort: RING_LOCK_LOSS_DETECT_EN.
module ring_heater_lock_ctrl
    import ring_lock_pkg::*;
#(
    parameter int unsigned BIT_WIDTH     = 8,
    parameter int unsigned PWR_WIDTH     = 10,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned STEP          = 1,
    parameter int unsigned LOSS_THRESH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pwr_valid,
    input  logic [PWR_WIDTH-1:0] pwr_code,
    output logic                 heater_pdm,
    output logic [BIT_WIDTH-1:0] heater_code,
    output logic                 locked,
    output logic                 sweep_busy
);

    localparam int unsigned          CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
    localparam logic [BIT_WIDTH-1:0] CODE_MAX    = '1;
    localparam logic [BIT_WIDTH-1:0] CODE_ONE    = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH:0]   STEP_EXT    = (BIT_WIDTH + 1)'(STEP);

    lock_state_t          state_q, state_d;
    logic [BIT_WIDTH-1:0] code_q, code_d;
    logic [BIT_WIDTH-1:0] best_code_q, best_code_d;
    logic [BIT_WIDTH-1:0] prev_code_q, prev_code_d;
    logic [PWR_WIDTH-1:0] best_pwr_q, best_pwr_d;
    logic [PWR_WIDTH-1:0] ref_pwr_q, ref_pwr_d;
    logic                 dir_q, dir_d;
    logic [CNT_W-1:0]     settle_q, settle_d;
    logic                 reload, accept, loss_abort;
    logic [BIT_WIDTH:0]   probe_up, probe_dn;
    logic [BIT_WIDTH-1:0] probe_code;
    logic                 probe_oob;

    always_comb accept = enable && pwr_valid && (settle_q == '0) && (state_q != IDLE);

    // The extra MSB is the carry/borrow that flags a probe outside the code range.
    always_comb begin
        probe_up = {1'b0, code_q} + STEP_EXT;
        probe_dn = {1'b0, code_q} - STEP_EXT;
        if (dir_q == DIR_UP) begin
            probe_oob  = probe_up[BIT_WIDTH];
            probe_code = probe_up[BIT_WIDTH-1:0];
        end else begin
            probe_oob  = probe_dn[BIT_WIDTH];
            probe_code = probe_dn[BIT_WIDTH-1:0];
        end
    end

`ifdef RING_LOCK_LOSS_DETECT_EN
    localparam int unsigned LOSS_W = $clog2(LOSS_COUNT + 1);

    logic [LOSS_W-1:0] loss_q;
    logic              loss_exceed;

    always_comb begin
        loss_exceed = {1'b0, pwr_code} > ({1'b0, ref_pwr_q} + (PWR_WIDTH + 1)'(LOSS_THRESH));
        loss_abort  = accept && (state_q == TRACK_REF) && loss_exceed &&
                      (loss_q == LOSS_W'(LOSS_COUNT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (!enable || loss_abort) begin
            loss_q <= '0;
        end else if (accept && (state_q == TRACK_REF)) begin
            loss_q <= loss_exceed ? loss_q + LOSS_W'(1) : '0;
        end
    end
`else
    always_comb loss_abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        best_code_d = best_code_q;
        best_pwr_d  = best_pwr_q;
        prev_code_d = prev_code_q;
        ref_pwr_d   = ref_pwr_q;
        dir_d       = dir_q;
        reload      = 1'b0;

        case (state_q)
            IDLE: begin
                code_d = '0;
                if (enable) begin
                    state_d     = SWEEP;
                    reload      = 1'b1;
                    best_pwr_d  = '1;
                    best_code_d = '0;
                end
            end
            SWEEP: begin
                if (accept) begin
                    if (pwr_code < best_pwr_q) begin
                        best_pwr_d  = pwr_code;
                        best_code_d = code_q;
                    end
                    reload = 1'b1;
                    if (code_q != CODE_MAX) begin
                        code_d = code_q + CODE_ONE;
                    end else begin
                        state_d   = TRACK_REF;
                        code_d    = best_code_d;
                        ref_pwr_d = best_pwr_d;
                    end
                end
            end
            TRACK_REF: begin
                if (loss_abort) begin
                    state_d     = SWEEP;
                    code_d      = '0;
                    reload      = 1'b1;
                    best_pwr_d  = '1;
                    best_code_d = '0;
                end else if (accept) begin
                    ref_pwr_d = pwr_code;
                    // At a range edge: turn around and re-measure without settling.
                    if (probe_oob) begin
                        dir_d = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
                    end else begin
                        prev_code_d = code_q;
                        code_d      = probe_code;
                        reload      = 1'b1;
                        state_d     = TRACK_PROBE;
                    end
                end
            end
            TRACK_PROBE: begin
                if (accept) begin
                    if (!(pwr_code < ref_pwr_q)) begin
                        code_d = prev_code_q;
                        dir_d  = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
                    end
                    reload  = 1'b1;
                    state_d = TRACK_REF;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase

        if (!enable) begin
            state_d = IDLE;
            code_d  = '0;
            reload  = 1'b0;
        end
    end

    always_comb settle_d = reload ? SETTLE_LOAD : ((settle_q != '0) ? settle_q - CNT_ONE : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= '0;
            best_code_q <= '0;
            best_pwr_q  <= '1;
            prev_code_q <= '0;
            ref_pwr_q   <= '0;
            dir_q       <= DIR_UP;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            best_code_q <= best_code_d;
            best_pwr_q  <= best_pwr_d;
            prev_code_q <= prev_code_d;
            ref_pwr_q   <= ref_pwr_d;
            dir_q       <= dir_d;
            settle_q    <= settle_d;
        end
    end

    pdm_modulator #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_pdm (
        .clk (clk),
        .rst (rst),
        .code(code_q),
        .pdm (heater_pdm)
    );

    assign heater_code = code_q;
    assign locked      = (state_q == TRACK_REF) || (state_q == TRACK_PROBE);
    assign sweep_busy  = (state_q == SWEEP);

endmodule

// File: tb/tb_ring_heater_lock_ctrl.sv
// Bench for ring_heater_lock_ctrl: behavioural lock-loop model plus a ring
// power plant driven from the model's heater code; per-cycle compare.
module tb_ring_heater_lock_ctrl;

    localparam int BW     = 4;
    localparam int PW     = 10;
    localparam int SETTLE = 4;
    localparam int STEPV  = 1;
    localparam int THRESH = 32;
    localparam int CMAX   = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          pwr_valid;
    logic [PW-1:0] pwr_code;
    logic          heater_pdm;
    logic [BW-1:0] heater_code;
    logic          locked;
    logic          sweep_busy;
    logic [7:0]    p8_code;
    logic          p8_pdm;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 0;

    always #5 clk = ~clk;

    ring_heater_lock_ctrl #(
        .BIT_WIDTH(BW), .PWR_WIDTH(PW), .SETTLE_CYCLES(SETTLE), .STEP(STEPV), .LOSS_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pwr_valid(pwr_valid), .pwr_code(pwr_code),
        .heater_pdm(heater_pdm), .heater_code(heater_code), .locked(locked), .sweep_busy(sweep_busy)
    );

    pdm_modulator #(.BIT_WIDTH(8)) u_pdm8 (.clk(clk), .rst(rst), .code(p8_code), .pdm(p8_pdm));

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // ---------------- behavioural model ----------------
    int m_code, m_acc, m_pdm, m_wait, m_best, m_bcode, m_ref, m_prev, m_dir, m_loss;
    bit m_sweeping, m_locked, m_probing, m_acc_ok, m_reload, m_abort;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_code = 0; m_acc = 0; m_pdm = 0; m_wait = 0; m_best = (1 << PW) - 1;
            m_bcode = 0; m_ref = 0; m_prev = 0; m_dir = 1; m_loss = 0;
            m_sweeping = 0; m_locked = 0; m_probing = 0;
        end else begin
            m_pdm = ((m_acc + m_code) >= (1 << BW)) ? 1 : 0;
            m_acc = (m_acc + m_code) % (1 << BW);
            m_acc_ok = enable && pwr_valid && (m_wait == 0) && (m_sweeping || m_locked);
            m_reload = 0;
            m_abort  = 0;
            if (!enable) begin
                m_code = 0; m_sweeping = 0; m_locked = 0; m_probing = 0; m_loss = 0;
            end else if (!m_sweeping && !m_locked) begin
                m_sweeping = 1; m_code = 0; m_reload = 1; m_best = (1 << PW) - 1; m_bcode = 0;
            end else if (m_acc_ok) begin
                if (m_sweeping) begin
                    if (int'(pwr_code) < m_best) begin m_best = pwr_code; m_bcode = m_code; end
                    m_reload = 1;
                    if (m_code != CMAX) m_code++;
                    else begin
                        m_sweeping = 0; m_locked = 1; m_code = m_bcode; m_ref = m_best;
                    end
                end else if (!m_probing) begin
`ifdef RING_LOCK_LOSS_DETECT_EN
                    if (int'(pwr_code) > m_ref + THRESH) begin
                        m_loss++;
                        if (m_loss == 4) m_abort = 1;
                    end else m_loss = 0;
`endif
                    if (m_abort) begin
                        m_loss = 0; m_locked = 0; m_sweeping = 1; m_code = 0; m_reload = 1;
                        m_best = (1 << PW) - 1; m_bcode = 0;
                    end else begin
                        m_ref = pwr_code;
                        if (m_code + m_dir * STEPV < 0 || m_code + m_dir * STEPV > CMAX) m_dir = -m_dir;
                        else begin
                            m_prev = m_code; m_code = m_code + m_dir * STEPV;
                            m_probing = 1; m_reload = 1;
                        end
                    end
                end else begin
                    if (!(int'(pwr_code) < m_ref)) begin m_code = m_prev; m_dir = -m_dir; end
                    m_probing = 0; m_reload = 1;
                end
            end
            m_wait = m_reload ? SETTLE : ((m_wait > 0) ? m_wait - 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_on) begin
            check("heater_code", heater_code, m_code);
            check("heater_pdm", heater_pdm, m_pdm);
            check("locked", locked, m_locked);
            check("sweep_busy", sweep_busy, m_sweeping);
        end
    end

    // ---------------- plant and stimulus ----------------
    int plant_mode = 0;
    int target     = 9;
    int offset     = 0;
    bit rnd_valid  = 0;

    function automatic int plant(input int c);
        int p;
        case (plant_mode)
            1:       p = ((iabs(c - 5) < iabs(c - 6)) ? iabs(c - 5) : iabs(c - 6)) * 50;
            2:       p = iabs(c - target) * 40 + int'($urandom_range(0, 20));
            default: p = iabs(c - target) * 50;
        endcase
        p = p + offset;
        return (p > 1023) ? 1023 : p;
    endfunction

    task automatic tick();
        @(negedge clk);
        pwr_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        pwr_code  = PW'(plant(m_code));
    endtask

    task automatic wait_locked(input string nm, input int budget);
        int n = 0;
        while (!locked && n < budget) begin tick(); n++; end
        check({nm, "_lock_timeout"}, locked, 1);
    endtask

    initial begin
        int ones, bad, dis;
        bit seen;
        rst = 1'b1; enable = 1'b0; pwr_valid = 1'b0; pwr_code = '0; p8_code = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_heater_code", heater_code, 0);
        check("rst_heater_pdm", heater_pdm, 0);
        check("rst_locked", locked, 0);
        check("rst_sweep_busy", sweep_busy, 0);
        rst = 1'b0;
        cmp_on = 1;

        p8_code = 8'd64;
        ones = 0;
        repeat (256) begin @(negedge clk); ones += p8_pdm; end
        check("pdm8_code64_ones", ones, 64);
        p8_code = 8'd0;
        ones = 0;
        repeat (256) begin @(negedge clk); ones += p8_pdm; end
        check("pdm8_code0_ones", ones, 0);

        // Settle window: pwr_valid held high but the first acceptance is 5 edges after entry.
        plant_mode = 0; target = 9;
        tick(); enable = 1'b1;
        repeat (5) tick();
        check("settle_ignored_code", heater_code, 0);
        tick();
        check("first_accept_code", heater_code, 1);
        wait_locked("sweep9", 200);
        check("sweep9_code", heater_code, 9);
        check("sweep9_busy", sweep_busy, 0);

        target = 11;
        seen = 0;
        for (int i = 0; i < 35 && !seen; i++) begin tick(); if (heater_code == 11) seen = 1; end
        check("track_reach_11", seen, 1);
        bad = 0;
        repeat (100) begin tick(); if (heater_code < 10 || heater_code > 12) bad++; end
        check("track_band_10_12", bad, 0);

        tick(); enable = 1'b0;
        repeat (3) tick();
        plant_mode = 1; enable = 1'b1;
        wait_locked("tie", 200);
        check("tie_code", heater_code, 5);

        plant_mode = 0; target = 5;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin tick(); if (m_probing) seen = 1; end
        check("reach_probe", seen, 1);
        #2 rst = 1'b1;
        #1;
        check("midprobe_rst_code", heater_code, 0);
        check("midprobe_rst_pdm", heater_pdm, 0);
        check("midprobe_rst_locked", locked, 0);
        check("midprobe_rst_busy", sweep_busy, 0);
        tick(); tick(); rst = 1'b0;

        rnd_valid = 1; plant_mode = 2; dis = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) target = $urandom_range(0, CMAX);
            if (dis > 0) begin dis--; enable = 1'b0; end
            else begin
                enable = 1'b1;
                if ($urandom_range(0, 199) == 0) dis = $urandom_range(1, 5);
            end
            tick();
        end
        enable = 1'b1;

`ifdef RING_LOCK_LOSS_DETECT_EN
        rnd_valid = 0; plant_mode = 0; target = 9;
        wait_locked("loss_relock", 300);
        for (int i = 0; i < 80 && locked; i++) begin tick(); offset += 20; end
        check("loss_locked", locked, 0);
        check("loss_busy", sweep_busy, 1);
        check("loss_code", heater_code, 0);
        offset = 0;
`endif
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
